// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, types and helpers for stream_mux_rr.
// Holds arbitration mode codes, lock states and a constant clog2.
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating or fixed priority encoder with pointer register.
// Ports: clk, rst, req, ptr (new pointer value), advance -> gnt, gnt_idx, any.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int CH_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            advance,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;

  // Scan from the far end so the nearest requester wins last.
  always_comb begin
    int idx;
    idx     = 0;
    any     = 1'b0;
    gnt_idx = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          any     = 1'b1;
          gnt_idx = CH_W'(i);
        end
      end
    end else begin
      for (int k = N_CH; k >= 1; k--) begin
        idx = (int'(ptr_q) + k) % N_CH;
        if (req[idx]) begin
          any     = 1'b1;
          gnt_idx = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= CH_W'(N_CH - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel to 1 valid/ready stream mux, registered output.
// Ports: clk, rst, in_valid/ready/data/last[N_CH] -> out_valid/ready/data/last/ch.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int PKT_LOCK = 1,
  localparam int CH_W    = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch
);

  lock_e           st_q, st_d;
  logic [CH_W-1:0] lch_q, lch_d;

  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              ol_q, ol_d;
  logic [CH_W-1:0]   oc_q, oc_d;

  logic [N_CH-1:0]   arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  logic              ld;
  logic              locked;
  logic [CH_W-1:0]   g;
  logic              g_ok;
  logic              acc;
  logic              last_g;
  logic [DATA_W-1:0] data_g;
  logic              adv;

  assign ld     = !ov_q || out_ready;
  assign locked = (st_q == LOCKED);
  assign g      = locked ? lch_q : arb_idx;
  assign g_ok   = locked || arb_any;
  assign last_g = in_last[g];
  assign data_g = in_data[g*DATA_W +: DATA_W];
  assign acc    = g_ok && in_valid[g] && in_ready[g];

  // Pointer only moves when an arbitration unit completes.
  assign adv = acc && (last_g || (PKT_LOCK == 0));

  rr_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE),
    .CH_W     (CH_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .ptr     (g),
    .advance (adv),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // A locked channel keeps ready even when it is not valid.
  always_comb begin
    in_ready = '0;
    if (ld && !rst) begin
      if (locked) in_ready[lch_q] = 1'b1;
      else        in_ready        = arb_gnt;
    end
  end

  always_comb begin
    st_d  = st_q;
    lch_d = lch_q;
    if (acc && (PKT_LOCK != 0)) begin
      if (last_g) begin
        st_d = UNLOCKED;
      end else begin
        st_d  = LOCKED;
        lch_d = g;
      end
    end
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    oc_d = oc_q;
    if (acc) begin
      ov_d = 1'b1;
      od_d = data_g;
      ol_d = last_g;
      oc_d = g;
    end else if (ld) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= UNLOCKED;
      lch_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
      oc_q  <= '0;
    end else begin
      st_q  <= st_d;
      lch_q <= lch_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      ol_q  <= ol_d;
      oc_q  <= oc_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign out_ch    = oc_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: three configurations of stream_mux_rr on shared inputs,
// checked against directed expectations and a transaction-level model.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0] rdy [3];
  logic         ov  [3];
  logic [W-1:0] od  [3];
  logic         ol  [3];
  logic [1:0]   oc  [3];

  // 0: round-robin + lock, 1: round-robin no lock, 2: fixed + lock
  int cfg_arb  [3] = '{0, 0, 1};
  int cfg_lock [3] = '{1, 0, 1};

  int           m_ptr [3];
  bit           m_lck [3];
  int           m_lch [3];
  logic         m_ov  [3];
  logic [W-1:0] m_od  [3];
  logic         m_ol  [3];
  logic [1:0]   m_oc  [3];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(N), .DATA_W(W), .ARB_MODE(0), .PKT_LOCK(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]), .out_ch(oc[0]));

  stream_mux_rr #(.N_CH(N), .DATA_W(W), .ARB_MODE(0), .PKT_LOCK(0)) u_nl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]), .out_ch(oc[1]));

  stream_mux_rr #(.N_CH(N), .DATA_W(W), .ARB_MODE(1), .PKT_LOCK(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]), .out_ch(oc[2]));

  function automatic int m_grant(int c);
    if (m_lck[c]) return m_lch[c];
    if (cfg_arb[c] == 1) begin
      for (int i = 0; i < N; i++) if (in_valid[i]) return i;
      return -1;
    end
    for (int k = 1; k <= N; k++)
      if (in_valid[(m_ptr[c] + k) % N]) return (m_ptr[c] + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready(int c);
    int g;
    logic [N-1:0] r;
    g = m_grant(c);
    r = '0;
    if (!rst && (!m_ov[c] || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic m_reset(int c);
    m_ptr[c] = N - 1;
    m_lck[c] = 0;
    m_lch[c] = 0;
    m_ov[c]  = 1'b0;
    m_od[c]  = '0;
    m_ol[c]  = 1'b0;
    m_oc[c]  = '0;
  endtask

  task automatic m_step(int c);
    int g;
    logic [N-1:0] r;
    if (rst) begin
      m_reset(c);
      return;
    end
    g = m_grant(c);
    r = m_ready(c);
    if (g >= 0 && r[g] && in_valid[g]) begin
      m_ov[c] = 1'b1;
      m_od[c] = in_data[g*W +: W];
      m_ol[c] = in_last[g];
      m_oc[c] = 2'(g);
      if (in_last[g] || cfg_lock[c] == 0) m_ptr[c] = g;
      if (cfg_lock[c] != 0) begin
        m_lck[c] = !in_last[g];
        m_lch[c] = g;
      end
    end else if (!m_ov[c] || out_ready) begin
      m_ov[c] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int c = 0; c < 3; c++) m_step(c);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 4'hF;
    in_last   = 4'hF;
    in_data   = 16'h4321;
    out_ready = 1'b1;
    rst       = 1'b1;
    cycle();
    for (int c = 0; c < 3; c++) begin
      n_tot++;
      if ({ov[c], od[c], ol[c], oc[c]} !== 8'h00)
        $display("FAIL reset_out[%0d] got %b want 0", c,
                 {ov[c], od[c], ol[c], oc[c]});
      else n_pass++;
      n_tot++;
      if (rdy[c] !== 4'b0000)
        $display("FAIL reset_ready[%0d] got %b want 0000", c, rdy[c]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    in_valid  = 4'b0100;
    in_data   = 16'h0A00;
    in_last   = 4'hF;
    out_ready = 1'b1;
    #1;
    n_tot++;
    if (rdy[0] !== 4'b0100)
      $display("FAIL single_ready got %b want 0100", rdy[0]);
    else n_pass++;
    cycle();
    n_tot++;
    if ({ov[0], od[0], oc[0]} !== {1'b1, 4'hA, 2'd2})
      $display("FAIL single_out got v=%b d=%h ch=%0d want v=1 d=a ch=2",
               ov[0], od[0], oc[0]);
    else n_pass++;
    in_valid = '0;
  endtask

  task automatic test_rr_fairness();
    do_reset();
    in_valid  = 4'hF;
    in_last   = 4'hF;
    in_data   = 16'h4321;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tot++;
      if ({ov[0], oc[0], od[0]} !== {1'b1, 2'(i % 4), 4'(i % 4 + 1)})
        $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h want ch=%0d",
                 i, ov[0], oc[0], od[0], i % 4);
      else n_pass++;
      n_tot++;
      if (oc[1] !== 2'(i % 4))
        $display("FAIL rr_seq_nolock[%0d] got %0d want %0d", i, oc[1], i % 4);
      else n_pass++;
    end
    in_valid = '0;
  endtask

  task automatic test_pkt_lock();
    int exp_l [4] = '{1, 1, 1, 2};
    int exp_n [4] = '{1, 2, 3, 0};
    do_reset();
    in_valid  = 4'b0001;
    in_last   = 4'hF;
    in_data   = 16'h4321;
    out_ready = 1'b1;
    cycle();
    in_valid = 4'hF;
    in_last  = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) in_last = 4'hF;
      cycle();
      n_tot++;
      if (oc[0] !== 2'(exp_l[i]) || ol[0] !== (i >= 2))
        $display("FAIL lock_seq[%0d] got ch=%0d l=%b want ch=%0d l=%0d",
                 i, oc[0], ol[0], exp_l[i], i >= 2);
      else n_pass++;
      n_tot++;
      if (oc[1] !== 2'(exp_n[i]))
        $display("FAIL nolock_seq[%0d] got %0d want %0d", i, oc[1], exp_n[i]);
      else n_pass++;
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid  = 4'b0010;
    in_data   = 16'h0050;
    in_last   = 4'hF;
    out_ready = 1'b1;
    cycle();
    n_tot++;
    if ({ov[0], od[0]} !== {1'b1, 4'h5})
      $display("FAIL bp_first got v=%b d=%h want v=1 d=5", ov[0], od[0]);
    else n_pass++;
    out_ready = 1'b0;
    in_data   = 16'h0060;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tot++;
      if (rdy[0] !== 4'b0000)
        $display("FAIL bp_ready[%0d] got %b want 0000", i, rdy[0]);
      else n_pass++;
      cycle();
      n_tot++;
      if ({ov[0], od[0]} !== {1'b1, 4'h5})
        $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=5",
                 i, ov[0], od[0]);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_tot++;
    if (rdy[0] !== 4'b0010)
      $display("FAIL bp_release_ready got %b want 0010", rdy[0]);
    else n_pass++;
    cycle();
    n_tot++;
    if ({ov[0], od[0]} !== {1'b1, 4'h6})
      $display("FAIL bp_next got v=%b d=%h want v=1 d=6", ov[0], od[0]);
    else n_pass++;
    in_valid = '0;
    cycle();
    n_tot++;
    if (ov[0] !== 1'b0)
      $display("FAIL bp_drain got v=%b want 0", ov[0]);
    else n_pass++;
  endtask

  task automatic test_fixed();
    do_reset();
    in_valid  = 4'b1010;
    in_last   = 4'hF;
    in_data   = 16'h3020;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tot++;
      if (rdy[2] !== 4'b0010)
        $display("FAIL fixed_ready[%0d] got %b want 0010", i, rdy[2]);
      else n_pass++;
      cycle();
      n_tot++;
      if ({ov[2], oc[2]} !== {1'b1, 2'd1})
        $display("FAIL fixed_ch[%0d] got v=%b ch=%0d want v=1 ch=1",
                 i, ov[2], oc[2]);
      else n_pass++;
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid  = 4'b0100;
    in_last   = 4'b1011;
    in_data   = 16'h0700;
    out_ready = 1'b1;
    cycle();
    in_valid = 4'b0101;
    cycle();
    n_tot++;
    if ({ov[0], oc[0]} !== {1'b1, 2'd2})
      $display("FAIL midrst_locked got v=%b ch=%0d want v=1 ch=2",
               ov[0], oc[0]);
    else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_tot++;
    if (ov[0] !== 1'b0)
      $display("FAIL midrst_flush got v=%b want 0", ov[0]);
    else n_pass++;
    cycle();
    n_tot++;
    if ({ov[0], oc[0]} !== {1'b1, 2'd0})
      $display("FAIL midrst_regrant got v=%b ch=%0d want v=1 ch=0",
               ov[0], oc[0]);
    else n_pass++;
    in_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      #1;
      for (int c = 0; c < 3; c++) begin
        n_tot++;
        if (rdy[c] !== m_ready(c))
          $display("FAIL rand_ready[%0d] cyc %0d got %b want %b",
                   c, i, rdy[c], m_ready(c));
        else n_pass++;
      end
      cycle();
      for (int c = 0; c < 3; c++) begin
        n_tot++;
        if ({ov[c], od[c], ol[c], oc[c]} !==
            {m_ov[c], m_od[c], m_ol[c], m_oc[c]})
          $display("FAIL rand_out[%0d] cyc %0d got %b want %b", c, i,
                   {ov[c], od[c], ol[c], oc[c]},
                   {m_ov[c], m_od[c], m_ol[c], m_oc[c]});
        else n_pass++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) m_reset(c);
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_rr_fairness();
    test_pkt_lock();
    test_backpressure();
    test_fixed();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
